// File: rtl/vga_pkg.sv
// Shared VGA timing constants and line-fetch FSM state type.
package vga_pkg;

   localparam int HD = 640;
   localparam int VD = 480;
   localparam int HT = 800;
   localparam int VT = 525;
   localparam int WORDS_PER_ROW = 20;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } fetch_state_e;

endpackage

// File: rtl/vga_palette.sv
// 16-entry colour palette: register file with combinational lookup.
module vga_palette
   import vga_pkg::*;
#(
   parameter int CD = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [3:0]    waddr,
   input  logic [CD-1:0] wdata,
   input  logic [3:0]    raddr,
   output logic [CD-1:0] rdata
);

   logic [CD-1:0] pal [16];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) pal[i] <= '0;
      end else if (we) begin
         pal[waddr] <= wdata;
      end
   end

   assign rdata = pal[raddr];

endmodule

// File: rtl/vga_line_fetch.sv
// Prefetches one 4bpp framebuffer row per line into a ping-pong buffer.
// VGA_FETCH_PALETTE_EN selects a 16-entry palette instead of grey output.
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int CD         = 12,
   parameter int FB_W       = 160,
   parameter int SCALE_LOG2 = 2,
   parameter int ADDR_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] fb_base,
   input  logic [10:0]       hc,
   input  logic [10:0]       vc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   input  logic              pal_we,
   input  logic [3:0]        pal_addr,
   input  logic [CD-1:0]     pal_wdata,
   output logic [CD-1:0]     rgb,
   output logic              busy,
   output logic              underrun,
   input  logic              underrun_clr
);

   localparam int WPR = FB_W / 8;
   localparam int CW  = CD / 3;

   fetch_state_e state, state_d;
   logic [10:0] hc_q;
   logic [4:0] idx, idx_d;
   logic [ADDR_W-1:0] addr_d, row;
   logic bank, bank_d;
   logic abort_q, abort_d;
   logic pend_q, pend_d;
   logic [10:0] pend_line_q, pend_line_d;
   logic underrun_d;

   logic trig, want, trig_busy, abort_now, pend_now;
   logic [10:0] nxt_line, pend_line_now, launch_line;
   logic done, wr_en, launch;

   logic [31:0] lbuf [2][WPR];

   assign trig = (hc == '0) && (hc_q != '0);
   assign nxt_line = (vc == 11'(VT - 1)) ? '0 : vc + 11'd1;
   assign want = trig && en && (nxt_line < 11'(VD));
   assign trig_busy = trig && (state != IDLE);
   assign abort_now = abort_q || trig_busy;
   assign pend_now = trig_busy ? want : pend_q;
   assign pend_line_now = trig_busy ? nxt_line : pend_line_q;

   assign mem_req = (state == REQ);
   assign busy = (state != IDLE);
   assign underrun_d = trig_busy || (underrun && !underrun_clr);

   always_comb begin
      state_d = state;
      idx_d = idx;
      addr_d = mem_addr;
      bank_d = bank;
      abort_d = abort_now;
      pend_d = pend_now;
      pend_line_d = pend_line_now;
      wr_en = 1'b0;
      launch = 1'b0;
      launch_line = nxt_line;
      done = 1'b0;
      unique case (state)
         IDLE: launch = want;
         REQ: begin
            if (mem_gnt) begin
               if (mem_rvalid) done = 1'b1;
               else state_d = WAIT;
            end
         end
         WAIT: done = mem_rvalid;
         default: state_d = IDLE;
      endcase
      // An aborted fetch drops its last word and hands over to the pending line.
      if (done) begin
         if (abort_now) begin
            abort_d = 1'b0;
            pend_d = 1'b0;
            state_d = IDLE;
            launch = pend_now;
            launch_line = pend_line_now;
         end else begin
            wr_en = 1'b1;
            if (idx == 5'(WPR - 1)) begin
               state_d = IDLE;
            end else begin
               state_d = REQ;
               idx_d = idx + 5'd1;
               addr_d = mem_addr + ADDR_W'(1);
            end
         end
      end
      row = ADDR_W'(launch_line >> SCALE_LOG2);
      if (launch) begin
         state_d = REQ;
         idx_d = '0;
         bank_d = launch_line[0];
         addr_d = fb_base + (row << 4) + (row << 2);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         hc_q <= '0;
         idx <= '0;
         mem_addr <= '0;
         bank <= 1'b0;
         abort_q <= 1'b0;
         pend_q <= 1'b0;
         pend_line_q <= '0;
         underrun <= 1'b0;
      end else begin
         state <= state_d;
         hc_q <= hc;
         idx <= idx_d;
         mem_addr <= addr_d;
         bank <= bank_d;
         abort_q <= abort_d;
         pend_q <= pend_d;
         pend_line_q <= pend_line_d;
         underrun <= underrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_en) lbuf[bank][idx] <= mem_rdata;
   end

   logic active;
   logic [10:0] pix;
   logic [4:0] rd_word;
   logic [31:0] rd_data;
   logic [3:0] nib;
   logic [CD-1:0] colour;

   assign active = reset && en && (hc < 11'(HD)) && (vc < 11'(VD));
   assign pix = hc >> SCALE_LOG2;
   assign rd_word = active ? 5'(pix >> 3) : '0;
   assign rd_data = lbuf[vc[0]][rd_word];
   assign nib = rd_data[{pix[2:0], 2'b00} +: 4];
   assign rgb = active ? colour : '0;

`ifdef VGA_FETCH_PALETTE_EN
   vga_palette #(
      .CD(CD)
   ) u_pal (
      .clk(clk),
      .reset(reset),
      .we(pal_we),
      .waddr(pal_addr),
      .wdata(pal_wdata),
      .raddr(nib),
      .rdata(colour)
   );
`else
   logic [CW-1:0] grey;
   logic unused_pal;

   assign unused_pal = ^{pal_we, pal_addr, pal_wdata};

   if (CW >= 4) begin : g_grey_up
      assign grey = CW'(nib) << (CW - 4);
   end else begin : g_grey_dn
      assign grey = CW'(nib >> (4 - CW));
   end

   always_comb begin
      colour = '0;
      colour[3*CW-1:0] = {grey, grey, grey};
   end
`endif

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed + randomized bench for vga_line_fetch with a memory responder
// and a behavioural line-buffer / colour reference model.
module tb_vga_line_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, en, underrun_clr, busy, underrun;
   logic [15:0] fb_base, mem_addr;
   logic [10:0] hc, vc;
   logic mem_req;
   logic mem_gnt = 1'b0;
   logic mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic pal_we;
   logic [3:0] pal_addr;
   logic [11:0] pal_wdata, rgb;

   vga_line_fetch dut (
      .clk(clk), .reset(reset), .en(en), .fb_base(fb_base),
      .hc(hc), .vc(vc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
      .rgb(rgb), .busy(busy), .underrun(underrun),
      .underrun_clr(underrun_clr)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_buf [2][20];
   bit ref_ok [2][20];
   logic [11:0] ref_pal [16];

   logic [15:0] addr_q [$];
   int rv_cnt = 0;
   int gnt_delay = 0;
   int lat_fix = -1;
   bit r_pend = 0;
   int r_cnt = 0;
   int gwait = 0;
   int rlat = 0;
   logic [15:0] r_addr = '0;

   function automatic logic [31:0] mdata(input logic [15:0] a);
      if (a == 16'h0114) return 32'h76543210;
      return {a ^ 16'h5A5A, ~a} * 32'h9E3779B1;
   endfunction

   // Memory: grant after gnt_delay cycles of request, data 0..3 cycles later.
   always @(negedge clk) begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (r_pend) begin
         if (r_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = mdata(r_addr);
            r_pend = 0;
            rv_cnt++;
         end else r_cnt--;
      end
      if (mem_req && !r_pend) begin
         if (gwait >= gnt_delay) begin
            gwait = 0;
            mem_gnt = 1'b1;
            addr_q.push_back(mem_addr);
            rlat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3, 0));
            if (rlat == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = mdata(mem_addr);
               rv_cnt++;
            end else begin
               r_pend = 1;
               r_cnt = rlat - 1;
               r_addr = mem_addr;
            end
         end else gwait++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic line_start(input int v);
      hc = 11'd799;
      step(2);
      vc = 11'(v);
      hc = '0;
      step(1);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   task automatic do_fetch(input int cur);
      int nxt, q0, r0;
      logic [15:0] a;
      nxt = (cur == 524) ? 0 : cur + 1;
      q0 = addr_q.size();
      r0 = rv_cnt;
      line_start(cur);
      chk("fetch_busy", 32'(busy), 1);
      wait_idle(400);
      chk("fetch_nreq", addr_q.size() - q0, 20);
      chk("fetch_nrvalid", rv_cnt - r0, 20);
      for (int i = 0; i < 20; i++) begin
         a = 16'(int'(fb_base) + (nxt / 4) * 20 + i);
         if (q0 + i < addr_q.size())
            chk($sformatf("fetch_addr_l%0d_w%0d", nxt, i), addr_q[q0 + i], a);
         ref_buf[nxt % 2][i] = mdata(a);
         ref_ok[nxt % 2][i] = 1;
      end
   endtask

   task automatic check_pix(input int h);
      int v, w;
      logic [31:0] wd;
      logic [3:0] n;
      logic [11:0] e;
      v = int'(vc);
      hc = 11'(h);
      #1;
      if (!reset || !en || h >= 640 || v >= 480) e = '0;
      else begin
         w = (h / 4) / 8;
         if (!ref_ok[v % 2][w]) begin
            step(1);
            return;
         end
         wd = ref_buf[v % 2][w];
         n = 4'((wd >> (4 * ((h / 4) % 8))) & 32'hF);
`ifdef VGA_FETCH_PALETTE_EN
         e = ref_pal[n];
`else
         e = {n, n, n};
`endif
      end
      chk($sformatf("rgb_h%0d_v%0d", h, v), 32'(rgb), 32'(e));
      step(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q0, k;
      logic [15:0] base;
      for (int i = 0; i < 16; i++) ref_pal[i] = '0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 20; i++) ref_ok[b][i] = 0;
      reset = 0; en = 1; hc = '0; vc = '0; fb_base = '0;
      pal_we = 0; pal_addr = '0; pal_wdata = '0; underrun_clr = 0;
      step(3);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_underrun", 32'(underrun), 0);
      check_pix(0);
      reset = 1;
      step(2);

      // Row 1 into bank 0, first word carries a ramp of nibbles.
      fb_base = 16'h0100;
      do_fetch(3);
      vc = 11'd4;
      for (int h = 0; h < 32; h++) check_pix(h);
      check_pix(700);
`ifndef VGA_FETCH_PALETTE_EN
      hc = 11'd3; #1; chk("lit_hc3", 32'(rgb), 32'h000);
      hc = 11'd4; #1; chk("lit_hc4", 32'(rgb), 32'h111);
      hc = 11'd28; #1; chk("lit_hc28", 32'(rgb), 32'h777);
      step(1);
`endif

      pal_addr = 4'd7; pal_wdata = 12'hF0A; pal_we = 1;
      step(1);
      pal_we = 0;
`ifdef VGA_FETCH_PALETTE_EN
      ref_pal[7] = 12'hF0A;
      hc = 11'd28; #1; chk("pal7", 32'(rgb), 32'hF0A);
`else
      hc = 11'd28; #1; chk("pal7_ignored", 32'(rgb), 32'h777);
`endif
      step(1);
      check_pix(29);

      // Wrap from the last line back to row 0.
      fb_base = 16'($urandom);
      do_fetch(524);
      vc = 11'd0;
      check_pix(0);
      repeat (6) check_pix(int'($urandom_range(639, 1)));

      q0 = addr_q.size();
      line_start(479);
      step(20);
      chk("l479_noreq", addr_q.size() - q0, 0);
      chk("l479_idle", 32'(busy), 0);
      vc = 11'd500;
      check_pix(100);

      en = 0;
      vc = 11'd4;
      check_pix(28);
      q0 = addr_q.size();
      line_start(10);
      step(20);
      chk("en0_noreq", addr_q.size() - q0, 0);
      chk("en0_idle", 32'(busy), 0);
      en = 1;

      for (int it = 0; it < 5; it++) begin
         int cur;
         fb_base = 16'($urandom);
         cur = int'($urandom_range(478, 0));
         do_fetch(cur);
         vc = 11'(cur + 1);
         check_pix(0);
         repeat (8) check_pix(int'($urandom_range(799, 1)));
      end

      // Reset while a read is outstanding; the late data must be discarded.
      fb_base = 16'h2000;
      do_fetch(98);
      lat_fix = 20;
      q0 = addr_q.size();
      line_start(100);
      k = 0;
      while (!(busy && !mem_req) && k < 50) begin
         step(1);
         k++;
      end
      chk("reach_wait", 32'(busy && !mem_req), 1);
      reset = 0;
      step(1);
      chk("rstmid_mem_req", 32'(mem_req), 0);
      chk("rstmid_busy", 32'(busy), 0);
      chk("rstmid_mem_addr", 32'(mem_addr), 0);
      check_pix(0);
      reset = 1;
      step(30);
      lat_fix = -1;
      chk("rstmid_one_req", addr_q.size() - q0, 1);
      chk("rstmid_idle", 32'(busy), 0);
      vc = 11'd99;
      check_pix(0);
      for (int h = 1; h < 32; h += 3) check_pix(h);

      // Slow grants: next line start arrives mid-fetch.
      base = 16'h4000;
      fb_base = base;
      gnt_delay = 100;
      lat_fix = 1;
      q0 = addr_q.size();
      line_start(10);
      step(250);
      chk("underrun_pre", 32'(underrun), 0);
      underrun_clr = 1;
      line_start(11);
      underrun_clr = 0;
      chk("underrun_set_wins", 32'(underrun), 1);
      for (int i = 0; i < 20; i++) ref_ok[1][i] = 0;
      gnt_delay = 0;
      lat_fix = -1;
      step(1);
      chk("underrun_sticky", 32'(underrun), 1);
      underrun_clr = 1;
      step(1);
      underrun_clr = 0;
      chk("underrun_clr", 32'(underrun), 0);
      wait_idle(400);
      k = addr_q.size() - q0 - 20;
      chk("abort_partial", 32'(k >= 1 && k <= 19), 1);
      for (int j = 0; j < k && j < 20; j++)
         chk($sformatf("abort_addr%0d", j), addr_q[q0 + j],
             16'(int'(base) + 2 * 20 + j));
      if (k >= 0) begin
         for (int i = 0; i < 20; i++) begin
            chk($sformatf("restart_addr%0d", i), addr_q[q0 + k + i],
                16'(int'(base) + 3 * 20 + i));
            ref_buf[0][i] = mdata(16'(int'(base) + 3 * 20 + i));
            ref_ok[0][i] = 1;
         end
      end
      chk("underrun_after", 32'(underrun), 0);
      vc = 11'd12;
      check_pix(0);
      repeat (8) check_pix(int'($urandom_range(639, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
